// File: rtl/seq_detector_pkg.sv
// Shared definitions for the 1011 serial pattern detector: state encoding
// and the pattern itself (first-received bit in the MSB).
package seq_detector_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_DET  = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector.sv
// Moore FSM that flags the serial pattern 1011 on x; z is high for the one
// cycle spent in S_DET. OVERLAP selects whether a match may seed the next one.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  // Kept as a plain vector so unused encodings (5..7) stay representable.
  logic [2:0] state_q;
  logic [2:0] state_d;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case infers a latch.
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = (x == PATTERN[3]) ? S_1   : S_IDLE;
      S_1:    state_d = (x == PATTERN[2]) ? S_10  : S_1;
      S_10:   state_d = (x == PATTERN[1]) ? S_101 : S_IDLE;
      S_101:  state_d = (x == PATTERN[0]) ? S_DET : S_10;
      // Non-overlapping mode forgets the matched "10" suffix after a hit.
      S_DET:  state_d = x ? S_1 : (OVERLAP ? S_10 : S_IDLE);
      default: state_d = S_IDLE;
    endcase
  end

  assign z = (state_q == S_DET);

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench: two detectors (overlapping and restarting) share one
// stimulus stream and are compared against a bit-history reference model.
module tb_seq_detector;
  import seq_detector_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic x;
  logic z_ov;
  logic z_no;

  int n_vec = 0;
  int n_err = 0;

  logic exp_ov = 1'b0;
  logic exp_no = 1'b0;
  bit   hist_ov[$];
  bit   hist_no[$];
  int   pulses_ov;
  int   pulses_no;

  always #5 clk = ~clk;

  seq_detector #(.OVERLAP(1'b1)) dut_ov (.clk(clk), .reset(reset), .x(x), .z(z_ov));
  seq_detector #(.OVERLAP(1'b0)) dut_no (.clk(clk), .reset(reset), .x(x), .z(z_no));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rule: a hit occurs when the bits received since the last
  // restart end with PATTERN.
  function automatic logic ends_with_pattern(input bit q[$]);
    logic [3:0] tail;
    int n;
    n = q.size();
    if (n < 4) return 1'b0;
    for (int i = 0; i < 4; i++) tail[3-i] = q[n-4+i];
    return tail == PATTERN;
  endfunction

  task automatic step(input string tag, input logic xv, input logic rv);
    @(negedge clk);
    x     = xv;
    reset = rv;
    @(posedge clk);
    if (rv) begin
      hist_ov.delete();
      hist_no.delete();
      exp_ov = 1'b0;
      exp_no = 1'b0;
    end else begin
      hist_ov.push_back(xv);
      hist_no.push_back(xv);
      if (hist_ov.size() > 8) void'(hist_ov.pop_front());
      if (hist_no.size() > 8) void'(hist_no.pop_front());
      exp_ov = ends_with_pattern(hist_ov);
      exp_no = ends_with_pattern(hist_no);
      if (exp_no) hist_no.delete();
    end
    #1;
    check({tag, "/ov"}, {31'd0, z_ov}, {31'd0, exp_ov});
    check({tag, "/no"}, {31'd0, z_no}, {31'd0, exp_no});
    pulses_ov += (z_ov === 1'b1) ? 1 : 0;
    pulses_no += (z_no === 1'b1) ? 1 : 0;
  endtask

  task automatic run_seq(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b0);
  endtask

  task automatic clear_pulses();
    pulses_ov = 0;
    pulses_no = 0;
  endtask

  initial begin
    reset = 1'b1;
    x     = 1'bx;
    clear_pulses();

    // Reset with unknown data input.
    step("rst_x", 1'bx, 1'b1);
    step("rst_x", 1'bx, 1'b1);
    check("rst_x_known", {31'd0, $isunknown(z_ov) | $isunknown(z_no)}, 32'd0);

    clear_pulses();
    run_seq("basic", 16'b1011, 4);
    check("basic_pulses_ov", pulses_ov, 32'd1);

    step("rst", 1'b0, 1'b1);
    clear_pulses();
    run_seq("overlap", 16'b1011011, 7);
    check("overlap_pulses_ov", pulses_ov, 32'd2);
    check("overlap_pulses_no", pulses_no, 32'd1);

    step("rst", 1'b0, 1'b1);
    clear_pulses();
    run_seq("nomatch", 16'b1110_1000, 8);
    check("nomatch_pulses", pulses_ov + pulses_no, 32'd0);

    step("rst", 1'b0, 1'b1);
    clear_pulses();
    run_seq("prefix", 16'b101011, 6);
    check("prefix_pulses_ov", pulses_ov, 32'd1);
    check("prefix_z_last", {31'd0, z_ov}, 32'd1);

    step("rst", 1'b0, 1'b1);
    clear_pulses();
    run_seq("midrst", 16'b101, 3);
    step("midrst", 1'b1, 1'b1);
    run_seq("midrst", 16'b1, 1);
    check("midrst_no_pulse", pulses_ov, 32'd0);
    run_seq("midrst", 16'b011, 3);
    check("midrst_pulse_ov", pulses_ov, 32'd1);
    check("midrst_z_last", {31'd0, z_ov}, 32'd1);

    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection and 0 = restart after each detection.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset, sampled on the rising clk edge.
REQ-004 SHALL have port x, input, 1 bit, meaning the serial data bit, sampled once per rising clk edge.
REQ-005 SHALL have port z, output, 1 bit, meaning detection flag, high for one cycle per detected pattern.
REQ-006 SHALL have one clock; reset is synchronous and active-high, and there are no other clocks, resets or enables.

Function
REQ-007 SHALL detect the serial pattern 1,0,1,1 (first-received bit first) on x.
REQ-008 SHALL be a Moore FSM; z SHALL depend only on the state register, never combinationally on x.
REQ-009 SHALL use five states: S_IDLE (no prefix), S_1 ("1"), S_10 ("10"), S_101 ("101"), S_DET ("1011" seen).
REQ-010 SHALL use these transitions as (x=0 / x=1):
- S_IDLE -> S_IDLE / S_1
- S_1 -> S_10 / S_1
- S_10 -> S_IDLE / S_101
- S_101 -> S_10 / S_DET
REQ-011 SHALL, when OVERLAP=1, transition S_DET -> S_10 on x=0 and S_DET -> S_1 on x=1.
REQ-012 SHALL, when OVERLAP=0, transition S_DET -> S_IDLE on x=0 and S_DET -> S_1 on x=1.
REQ-013 SHALL drive z=1 exactly while the state is S_DET, and z=0 in every other state.
REQ-014 SHALL have a latency of one edge: the edge that samples the final 1 enters S_DET, and z is high for the following full clock cycle.
REQ-015 SHALL, with OVERLAP=1, keep z pulsing as single-cycle pulses for back-to-back overlapping patterns (e.g. 1011011 gives two pulses three cycles apart).
REQ-016 SHALL recover any illegal or unreachable state encoding to S_IDLE on the next edge with z=0.
REQ-017 SHALL remain deterministic when x is unknown (X) during reset: reset dominates, and x is ignored on any edge where reset=1.

Reset
REQ-018 SHALL, on any rising edge with reset=1, enter S_IDLE, so that z=0 in the following cycle, regardless of x or current state.
REQ-019 SHALL discard any partial match when reset is asserted mid-pattern; detection restarts from the first bit after reset deasserts.
REQ-020 SHALL begin sampling x on the first rising edge where reset=0.

Structure
REQ-021 SHALL place the state enumeration typedef (5 states, 3-bit encoding) and the pattern constant 4'b1011 in a shared package, seq_detector_pkg.
REQ-022 SHALL be one module with no sub-modules: a state register process, a next-state decode, and an output decode.

Verification
REQ-023 SHALL cover basic detection: after reset, drive x = 1,0,1,1 on consecutive edges -> z=1 for exactly the cycle after the 4th edge, and z=0 otherwise.
REQ-024 SHALL cover overlap: with OVERLAP=1, drive x = 1,0,1,1,0,1,1 -> z pulses after edges 4 and 7. With OVERLAP=0, the same stream -> a pulse after edge 4 only.
REQ-025 SHALL cover non-matches: drive 1,1,1,0 then 1,0,0,0 -> z stays 0 throughout.
REQ-026 SHALL cover prefix recovery: drive 1,0,1,0,1,1 -> a single z pulse after edge 6, exercising the S_101 -> S_10 path.
REQ-027 SHALL cover reset mid-pattern: drive 1,0,1, assert reset for one edge, then drive 1 -> z stays 0. Then drive 0,1,1 -> z pulses after the last edge (new 1,0,1,1).
REQ-028 SHALL cover reset with unknown input: hold reset=1 with x=X for 2 edges -> z=0 and state S_IDLE, with no X propagating to z.
